// File: rtl/hex_scan_display_pkg.sv
// Shared constants, the hex-to-segment table and the index-width helper for the
// multiplexed seven-segment scanner and its decoder.
package hex_scan_pkg;

   localparam int SEG_W = 7;
   localparam int NIB_W = 4;

   // Segment order is {a,b,c,d,e,f,g}, active high; lower-case b and d for 0xB/0xD.
   localparam logic [SEG_W-1:0] SEG_HEX [0:15] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   function automatic int idx_w(input int digits);
      return (digits <= 2) ? 1 : $clog2(digits);
   endfunction

endpackage

// File: rtl/hex_scan_display_if.sv
// Producer-side bus of the hex scanner: data/load/mask/brightness in, pins out.
// HEX_SCAN_LZ_BLANK_EN adds the lz_blank control.
interface hex_scan_if
   import hex_scan_pkg::*;
#(
   parameter int DIGITS = 8
);
   logic [NIB_W*DIGITS-1:0] data;
   logic                    load;
   logic [DIGITS-1:0]       blank_mask;
   logic [3:0]              brightness;
`ifdef HEX_SCAN_LZ_BLANK_EN
   logic                    lz_blank;
`endif
   logic [DIGITS-1:0]       anodes;
   logic [SEG_W-1:0]        segments;
   logic                    frame;

   modport master (
`ifdef HEX_SCAN_LZ_BLANK_EN
      output lz_blank,
`endif
      output data, load, blank_mask, brightness,
      input  anodes, segments, frame
   );

   modport slave (
`ifdef HEX_SCAN_LZ_BLANK_EN
      input  lz_blank,
`endif
      input  data, load, blank_mask, brightness,
      output anodes, segments, frame
   );
endinterface

// File: rtl/hex_scan_display_hex7seg.sv
// Combinational hex nibble to seven-segment decoder, shared by display blocks.
module hex7seg
   import hex_scan_pkg::*;
(
   input  logic [NIB_W-1:0] nib_i,
   output logic [SEG_W-1:0] seg_o
);
   assign seg_o = SEG_HEX[nib_i];
endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed seven-segment scanner with prescaler, double-buffered data, PWM
// brightness and frame pulse. Optional leading-zero blanking: HEX_SCAN_LZ_BLANK_EN.
module hex_scan_display
   import hex_scan_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 4096
) (
   input  logic      clk,
   input  logic      rst,
   hex_scan_if.slave bus
);
   localparam int IW   = idx_w(DIGITS);
   localparam int PW   = $clog2(SCAN_DIV);
   localparam int DW   = NIB_W * DIGITS;
   localparam int STEP = SCAN_DIV / 16;

   logic [PW-1:0]    pre_q, pre_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [DW-1:0]    staging_q, staging_d;
   logic [DW-1:0]    shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic [DIGITS-1:0] anodes_q, anodes_d;
   logic [SEG_W-1:0] segments_q, segments_d;
   logic             frame_q, frame_d;

   logic             tick, last, boundary, on, lz_dark;
   logic [PW:0]      thresh;
   logic [NIB_W-1:0] nib;
   logic [SEG_W-1:0] seg_dec;

   hex7seg u_dec (
      .nib_i (nib),
      .seg_o (seg_dec)
   );

`ifdef HEX_SCAN_LZ_BLANK_EN
   logic [IW-1:0] msd;
   always_comb begin
      msd = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (shadow_q[NIB_W*i +: NIB_W] != '0) msd = IW'(i);
      end
      lz_dark = bus.lz_blank && (idx_q > msd);
   end
`else
   assign lz_dark = 1'b0;
`endif

   always_comb begin
      tick     = (pre_q == PW'(SCAN_DIV - 1));
      last     = (idx_q == IW'(DIGITS - 1));
      boundary = tick && last;

      pre_d = tick ? '0 : pre_q + 1'b1;
      idx_d = idx_q;
      if (tick) idx_d = last ? '0 : idx_q + 1'b1;

      staging_d = staging_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (bus.load) staging_d = bus.data;
      // A load landing on the boundary tick bypasses staging so it is not lost a frame.
      if (boundary) begin
         pending_d = 1'b0;
         if (bus.load)      shadow_d = bus.data;
         else if (pending_q) shadow_d = staging_q;
      end else if (bus.load) begin
         pending_d = 1'b1;
      end

      frame_d = boundary;

      nib    = shadow_q[NIB_W*idx_q +: NIB_W];
      thresh = (PW+1)'((int'(bus.brightness) + 1) * STEP);
      on     = (pre_q != '0) && ({1'b0, pre_q} < thresh) &&
               !bus.blank_mask[idx_q] && !lz_dark;

      anodes_d = '0;
      if (on) anodes_d[idx_q] = 1'b1;
      segments_d = on ? seg_dec : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q      <= '0;
         idx_q      <= '0;
         staging_q  <= '0;
         shadow_q   <= '0;
         pending_q  <= 1'b0;
         anodes_q   <= '0;
         segments_q <= '0;
         frame_q    <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         staging_q  <= staging_d;
         shadow_q   <= shadow_d;
         pending_q  <= pending_d;
         anodes_q   <= anodes_d;
         segments_q <= segments_d;
         frame_q    <= frame_d;
      end
   end

   assign bus.anodes   = anodes_q;
   assign bus.segments = segments_q;
   assign bus.frame    = frame_q;

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
- Parametrised multiplexed seven-segment scanner; successor to the fixed 8-digit hex display driver.
- Contains its own scan prescaler, so it runs directly from the board clock with no external divider.
- Adds tear-free double-buffered data load, per-digit blanking, 16-level PWM brightness and a frame-done pulse.
- Sits between the data producers (counters, clicker) and the board-level pin inversion/remap.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
SCAN_DIV, 4096, clk cycles per digit slot; must be a multiple of 16 and at least 16

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
data  input  4*DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 = rightmost
load  input  1  capture data into the staging register this cycle
blank_mask  input  DIGITS  1 = force digit i dark; sampled live, not buffered
brightness  input  4  duty level; 0 = 1/16 on, 15 = fully on
anodes  output  DIGITS  one-hot active-high digit enable
segments  output  7  active-high {a,b,c,d,e,f,g}
frame  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset is asynchronous and active-high. It clears the prescaler, digit index, staging register, shadow register, pending flag, anodes, segments and frame to 0.
- Prescaler pre counts 0..SCAN_DIV-1 and wraps. tick = (pre == SCAN_DIV-1).
- Digit index idx advances on tick and wraps from DIGITS-1 to 0.
- frame = registered (tick && idx == DIGITS-1). It is high for exactly one cycle, in the cycle after the wrap edge.
- Double buffering:
  - load=1 copies data into staging and sets pending.
  - On the frame-boundary tick, if pending is set: shadow <= staging, pending <= 0.
  - If load coincides with the boundary tick, that cycle's data goes straight to shadow and pending stays 0.
  - The display only ever shows shadow, so no frame mixes old and new data.
- Digit output:
  - nib = shadow[4*idx +: 4], decoded through the hex7seg table (0-F, standard a-g).
  - on = (pre < (brightness+1)*(SCAN_DIV/16)) && !blank_mask[idx].
  - anodes <= on ? (1 << idx) : 0.
  - segments <= on ? decoded nib : 0.
  - Both outputs are registered: one cycle of latency from the pre/idx state.
- Anti-ghosting: segments and anodes are both 0 in the first cycle of every slot (pre == 0), regardless of brightness.
- brightness is sampled every cycle; a change takes effect within the current slot.
- Deasserting reset mid-scan restarts at idx 0, pre 0, with a blank shadow.
- With DIGITS=1, idx stays 0 and frame pulses every SCAN_DIV cycles.

Optional Feature:
- Macro: HEX_SCAN_LZ_BLANK_EN.
- When defined, adds input lz_blank (1 bit). If lz_blank=1, every digit above the most significant non-zero nibble of shadow is dark. Digit 0 is always shown, so all-zero data displays "0". This combines (OR) with blank_mask.
- When undefined, the port does not exist and there is no leading-zero logic.

Decomposition:
- Package hex_scan_pkg:
  - SEG_W = 7.
  - NIB_W = 4.
  - 16-entry localparam segment table SEG_HEX.
  - Function idx_w(DIGITS) giving clog2 with a minimum of 1.
- Sub-module hex7seg: purely combinational 4-bit -> 7-bit decoder using SEG_HEX. It is reused by the top level and other display blocks.

Test Plan:
- Bench parameters: DIGITS=4, SCAN_DIV=16, brightness=15.
- Reset release, load data=16'h1234:
  - Pulses: anodes shows 0001 with segments=7'b0110011 ("4"), then 0010/"3", 0100/"2", 1000/"1".
  - Timing: each digit is 15 cycles on plus 1 blank cycle.
  - frame pulses every 64 cycles.
- Tear-free update:
  - Stimulus: load 16'hABCD during slot of digit 1.
  - Required: digits 2 and 3 still show "2" and "1" for the rest of the frame. The next frame shows D, C, B, A.
- Load on boundary tick:
  - Stimulus: load=1 exactly when idx=3, pre=15.
  - Required: the next frame shows the new value and pending reads 0.
- Brightness:
  - brightness=3 gives the anode high for cycles pre=1..3 of each slot (3 cycles on, 13 off).
  - brightness=0 gives 0 cycles on (pre=0 is forced blank).
- blank_mask=4'b0100: the digit 2 slot has anodes=0 and segments=0. Other digits are unaffected.
- Async reset asserted mid-slot: anodes=0 and segments=0 immediately, without waiting for a clock edge. After release, scan restarts at digit 0 showing "0".
- HEX_SCAN_LZ_BLANK_EN defined, lz_blank=1, data=16'h0050:
  - Digits 3 and 2 are dark.
  - Digit 1 shows "5" and digit 0 shows "0".
  - data=0 shows only digit 0 as "0".
